// File: rtl/aes_pkg.sv
// Shared definitions for the AES decrypt scheduler.
// Holds the scheduler state encoding, the key/block widths and the default
// watchdog limit. It also holds a small helper that maps a one-hot
// two-requester grant onto a requester id.
package aes_pkg;

    localparam int KEY_W              = 256;
    localparam int BLK_W              = 128;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEY_EXP = 3'd1,
        ST_READY   = 3'd2,
        ST_DECRYPT = 3'd3,
        ST_RESP    = 3'd4
    } sched_state_e;

    // One-hot grant (2'b01 / 2'b10) to requester id.
    function automatic logic grant_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/aes_decrypt_scheduler_if.sv
// Bus bundle between the AES decrypt scheduler and its environment.
//
// Signal groups:
//   key side       : key_load, key_in, key_ready
//   requester side : req_valid[1:0], req_ready[1:0], req_cipher0, req_cipher1
//   response side  : resp_valid, resp_ready, resp_id, resp_plain
//   core side      : core_key_start, core_start, core_key, core_cipher,
//                    core_plain, core_finished, core_key_finished
//   status         : timeout_err
//
// Modports:
//   slave  - the scheduler
//   master - requesters, consumer and decryption core around it
interface aes_decrypt_scheduler_if;

    logic                       key_load;
    logic [aes_pkg::KEY_W-1:0]  key_in;
    logic                       key_ready;
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [aes_pkg::BLK_W-1:0]  req_cipher0;
    logic [aes_pkg::BLK_W-1:0]  req_cipher1;
    logic                       resp_valid;
    logic                       resp_ready;
    logic                       resp_id;
    logic [aes_pkg::BLK_W-1:0]  resp_plain;
    logic                       core_key_start;
    logic                       core_start;
    logic [aes_pkg::KEY_W-1:0]  core_key;
    logic [aes_pkg::BLK_W-1:0]  core_cipher;
    logic [aes_pkg::BLK_W-1:0]  core_plain;
    logic                       core_finished;
    logic                       core_key_finished;
    logic                       timeout_err;

    modport slave (
        input  key_load, key_in, req_valid, req_cipher0, req_cipher1, resp_ready,
               core_plain, core_finished, core_key_finished,
        output key_ready, req_ready, resp_valid, resp_id, resp_plain,
               core_key_start, core_start, core_key, core_cipher, timeout_err
    );

    modport master (
        output key_load, key_in, req_valid, req_cipher0, req_cipher1, resp_ready,
               core_plain, core_finished, core_key_finished,
        input  key_ready, req_ready, resp_valid, resp_id, resp_plain,
               core_key_start, core_start, core_key, core_cipher, timeout_err
    );

endinterface

// File: rtl/aes_decrypt_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter (module rr_arbiter2).
// The pointer names the favoured requester. It moves to the other requester
// only when a grant is actually taken, as signalled by advance_i.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req_i      : pending requests
//   advance_i  : a transfer happened this cycle
//   win_id_i   : requester that transferred
//   grant_o    : one-hot combinational pick (2'b00 when nothing pending)
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       win_id_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // Pick the favoured requester if it asks, otherwise the other one
    always_comb begin
        grant_o = 2'b00;
        if (ptr_q) begin
            if (req_i[1])      grant_o = 2'b10;
            else if (req_i[0]) grant_o = 2'b01;
            else               grant_o = 2'b00;
        end else begin
            if (req_i[0])      grant_o = 2'b01;
            else if (req_i[1]) grant_o = 2'b10;
            else               grant_o = 2'b00;
        end
    end

    // After a taken grant the other requester becomes favoured
    always_comb begin
        if (advance_i) ptr_d = ~win_id_i;
        else           ptr_d = ptr_q;
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/aes_decrypt_scheduler.sv
// AES-256 decrypt scheduler: loads a key into an external decryption core and
// serves two requesters round-robin. Each block's plaintext is returned with
// the id of the requester that owns it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aes_decrypt_scheduler_if.slave (key, requests, response, core, status)
// Parameter:
//   TIMEOUT_CYCLES : watchdog limit for one key expansion or one decryption
// Optional feature macro AES_SCHED_WATCHDOG_EN: when it is defined, a watchdog
// counts in KEY_EXP/DECRYPT. On expiry it sets the sticky timeout_err flag and
// drops back to IDLE. When it is undefined, timeout_err is tied low.
module aes_decrypt_scheduler
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_decrypt_scheduler_if.slave bus
);

    sched_state_e       state_q;
    logic               key_ready_q;
    logic [1:0]         req_ready_q;
    logic               resp_valid_q;
    logic               resp_id_q;
    logic [BLK_W-1:0]   resp_plain_q;
    logic               core_key_start_q;
    logic               core_start_q;
    logic [KEY_W-1:0]   core_key_q;
    logic [BLK_W-1:0]   core_cipher_q;
    logic               id_q;
    logic               key_pend_q;
    logic [KEY_W-1:0]   key_pend_val_q;

    logic [1:0]         grant_s;
    logic               xfer_s;
    logic               pend_now_s;
    logic [KEY_W-1:0]   pend_key_s;

`ifdef AES_SCHED_WATCHDOG_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    logic [WD_W-1:0]    wd_cnt_q;
    logic               timeout_err_q;
`endif

    // A grant offered last cycle is taken when its requester is still valid
    assign xfer_s = |(bus.req_valid & req_ready_q);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.req_valid),
        .advance_i (xfer_s),
        .win_id_i  (grant_id(req_ready_q)),
        .grant_o   (grant_s)
    );

    // A key_load arriving in the same cycle beats an older pending key
    always_comb begin
        if (bus.key_load) begin
            pend_now_s = 1'b1;
            pend_key_s = bus.key_in;
        end else begin
            pend_now_s = key_pend_q;
            pend_key_s = key_pend_val_q;
        end
    end

    // Scheduler FSM; every output is a register written here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            key_ready_q      <= 1'b0;
            req_ready_q      <= 2'b00;
            resp_valid_q     <= 1'b0;
            resp_id_q        <= 1'b0;
            resp_plain_q     <= {BLK_W{1'b0}};
            core_key_start_q <= 1'b0;
            core_start_q     <= 1'b0;
            core_key_q       <= {KEY_W{1'b0}};
            core_cipher_q    <= {BLK_W{1'b0}};
            id_q             <= 1'b0;
            key_pend_q       <= 1'b0;
            key_pend_val_q   <= {KEY_W{1'b0}};
`ifdef AES_SCHED_WATCHDOG_EN
            wd_cnt_q         <= {WD_W{1'b0}};
            timeout_err_q    <= 1'b0;
`endif
        end else begin
            core_key_start_q <= 1'b0;
            core_start_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.key_load) begin
                        core_key_q       <= bus.key_in;
                        core_key_start_q <= 1'b1;
                        state_q          <= ST_KEY_EXP;
                    end
                end
                ST_KEY_EXP: begin
                    // core_key stays fixed while the core expands it; a newer key waits
                    if (bus.core_key_finished) begin
                        if (pend_now_s) begin
                            core_key_q       <= pend_key_s;
                            core_key_start_q <= 1'b1;
                            key_pend_q       <= 1'b0;
                        end else begin
                            key_ready_q <= 1'b1;
                            state_q     <= ST_READY;
                        end
                    end else if (bus.key_load) begin
                        key_pend_q     <= 1'b1;
                        key_pend_val_q <= bus.key_in;
                    end
                end
                ST_READY: begin
                    // Grants are one-cycle offers; an untaken offer is withdrawn and re-decided
                    req_ready_q <= 2'b00;
                    if (xfer_s) begin
                        core_cipher_q <= req_ready_q[1] ? bus.req_cipher1 : bus.req_cipher0;
                        id_q          <= grant_id(req_ready_q);
                        core_start_q  <= 1'b1;
                        state_q       <= ST_DECRYPT;
                        if (bus.key_load) begin
                            key_pend_q     <= 1'b1;
                            key_pend_val_q <= bus.key_in;
                            key_ready_q    <= 1'b0;
                        end
                    end else if (bus.key_load) begin
                        core_key_q       <= bus.key_in;
                        core_key_start_q <= 1'b1;
                        key_ready_q      <= 1'b0;
                        state_q          <= ST_KEY_EXP;
                    end else if (key_ready_q && (req_ready_q == 2'b00)) begin
                        req_ready_q <= grant_s;
                    end
                end
                ST_DECRYPT: begin
                    if (bus.key_load) begin
                        key_pend_q     <= 1'b1;
                        key_pend_val_q <= bus.key_in;
                        key_ready_q    <= 1'b0;
                    end
                    if (bus.core_finished) begin
                        resp_plain_q <= bus.core_plain;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        if (pend_now_s) begin
                            core_key_q       <= pend_key_s;
                            core_key_start_q <= 1'b1;
                            key_pend_q       <= 1'b0;
                            key_ready_q      <= 1'b0;
                            state_q          <= ST_KEY_EXP;
                        end else begin
                            state_q <= ST_READY;
                        end
                    end else if (bus.key_load) begin
                        key_pend_q     <= 1'b1;
                        key_pend_val_q <= bus.key_in;
                        key_ready_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
`ifdef AES_SCHED_WATCHDOG_EN
            // Count only while waiting on the core; a finish in the same cycle is not a timeout
            if (((state_q == ST_KEY_EXP) && !bus.core_key_finished) ||
                ((state_q == ST_DECRYPT) && !bus.core_finished)) begin
                if (wd_cnt_q == WD_LAST) begin
                    timeout_err_q    <= 1'b1;
                    state_q          <= ST_IDLE;
                    key_ready_q      <= 1'b0;
                    key_pend_q       <= 1'b0;
                    core_key_start_q <= 1'b0;
                    wd_cnt_q         <= {WD_W{1'b0}};
                end else begin
                    wd_cnt_q <= wd_cnt_q + WD_ONE;
                end
            end else begin
                wd_cnt_q <= {WD_W{1'b0}};
            end
`endif
        end
    end

    assign bus.key_ready      = key_ready_q;
    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_id        = resp_id_q;
    assign bus.resp_plain     = resp_plain_q;
    assign bus.core_key_start = core_key_start_q;
    assign bus.core_start     = core_start_q;
    assign bus.core_key       = core_key_q;
    assign bus.core_cipher    = core_cipher_q;
`ifdef AES_SCHED_WATCHDOG_EN
    assign bus.timeout_err    = timeout_err_q;
`else
    assign bus.timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// Directed bench for aes_decrypt_scheduler with a behavioural decryption core
// (12-cycle expansion, 14-cycle decryption). The core returns the FIPS-197
// AES-256 vector for that key/cipher pair and a simple xor mix otherwise.
module tb_aes_decrypt_scheduler;
    import aes_pkg::*;

    localparam logic [255:0] K0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K1 = 256'h5a5a0000ffff1234abcd9876deadbeef0badf00d13572468ace0bdf102468ace;
    localparam logic [127:0] C0 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'hcafef00d0123456789abcdef55aa33cc;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic model_rst_n = 1'b0;
    logic hang        = 1'b0;
    int   n_tests     = 0;
    int   n_fail      = 0;

    aes_decrypt_scheduler_if bus();

    aes_decrypt_scheduler #(.TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] core_dec(input logic [255:0] k, input logic [127:0] c);
        if (k == K0 && c == C0) return P0;
        return c ^ k[127:0] ^ k[255:128];
    endfunction

    // Behavioural core; it has its own reset so it keeps running across a DUT reset.
    int            kcnt;
    int            dcnt;
    logic [255:0]  m_key;
    logic [127:0]  m_cip;
    always @(posedge clk or negedge model_rst_n) begin
        if (!model_rst_n) begin
            kcnt <= 0; dcnt <= 0; m_key <= '0; m_cip <= '0;
            bus.core_key_finished <= 1'b0; bus.core_finished <= 1'b0; bus.core_plain <= '0;
        end else begin
            bus.core_key_finished <= 1'b0;
            bus.core_finished     <= 1'b0;
            if (bus.core_key_start) begin
                m_key <= bus.core_key; kcnt <= 12;
            end else if (kcnt > 0) begin
                kcnt <= kcnt - 1;
                if (kcnt == 1) bus.core_key_finished <= 1'b1;
            end
            if (bus.core_start) begin
                m_cip <= bus.core_cipher; dcnt <= 14;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1 && !hang) begin
                    bus.core_finished <= 1'b1;
                    bus.core_plain    <= core_dec(m_key, m_cip);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return |bus.req_ready;
            1:       return bus.resp_valid;
            2:       return bus.key_ready;
            3:       return bus.core_finished;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait on negedges; an expired budget shows as a failed comparison.
    task automatic wait_for(input string tag, input int sel, input int budget);
        int n;
        n = 0;
        while (probe(sel) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 256'(probe(sel)), 256'd1);
    endtask

    task automatic load_key(input string tag, input logic [255:0] k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        @(negedge clk);
        bus.key_load = 1'b0;
        check({tag, " key_start"}, 256'({bus.core_key_start, bus.core_key}), 256'({1'b1, k}));
        @(negedge clk);
        check({tag, " key_pulse"}, 256'({bus.core_key_start, bus.key_ready}), 256'd0);
        wait_for({tag, " key_ready"}, 2, 40);
    endtask

    // One block: offer, grant, core start, response, optional hold and mid-decrypt key load.
    task automatic do_block(input string tag, input logic [1:0] valid, input logic exp_id,
                            input logic [255:0] key, input int hold, input int kl_at,
                            input logic [255:0] kl_key);
        logic [127:0] cip;
        logic [127:0] exp_plain;
        cip       = exp_id ? bus.req_cipher1 : bus.req_cipher0;
        exp_plain = core_dec(key, cip);
        bus.req_valid = valid;
        wait_for({tag, " grant"}, 0, 20);
        check({tag, " req_ready"}, 256'(bus.req_ready), 256'(exp_id ? 2'b10 : 2'b01));
        @(negedge clk);
        check({tag, " core_start"}, 256'({bus.core_start, bus.core_cipher}), 256'({1'b1, cip}));
        check({tag, " core_key"}, bus.core_key, key);
        @(negedge clk);
        check({tag, " start_pulse"}, 256'(bus.core_start), 256'd0);
        if (kl_at >= 0) begin
            repeat (kl_at) @(negedge clk);
            bus.key_in   = kl_key;
            bus.key_load = 1'b1;
            @(negedge clk);
            bus.key_load = 1'b0;
            check({tag, " key_ready_drop"}, 256'(bus.key_ready), 256'd0);
        end
        wait_for({tag, " core_finished"}, 3, 30);
        @(negedge clk);
        check({tag, " resp"}, 256'({bus.resp_valid, bus.resp_id, bus.resp_plain}),
              256'({1'b1, exp_id, exp_plain}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, 256'({bus.resp_valid, bus.resp_id, bus.resp_plain, bus.core_start, bus.req_ready}),
                  256'({1'b1, exp_id, exp_plain, 1'b0, 2'b00}));
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, " resp_done"}, 256'(bus.resp_valid), 256'd0);
        if (kl_at >= 0) begin
            check({tag, " new_key_start"}, 256'({bus.core_key_start, bus.core_key}), 256'({1'b1, kl_key}));
            wait_for({tag, " new_key_ready"}, 2, 40);
            check({tag, " no_grant_before_key"}, 256'(bus.req_ready), 256'd0);
        end
    endtask

    initial begin
        int n;
        int seen;
        bus.key_load    = 1'b0;
        bus.key_in      = '0;
        bus.req_valid   = 2'b00;
        bus.req_cipher0 = C0;
        bus.req_cipher1 = CA;
        bus.resp_ready  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst ctrl", 256'({bus.key_ready, bus.req_ready, bus.resp_valid, bus.resp_id,
                                bus.core_key_start, bus.core_start, bus.timeout_err}), 256'd0);
        check("rst data", 256'({bus.resp_plain, bus.core_cipher}), 256'd0);
        check("rst key", bus.core_key, 256'd0);
        rst_n       = 1'b1;
        model_rst_n = 1'b1;
        @(negedge clk);

        load_key("K0", K0);
        do_block("A", 2'b01, 1'b0, K0, 10, -1, '0);          // FIPS vector, held response
        do_block("B", 2'b11, 1'b1, K0, 0, -1, '0);           // pointer at 1: grant 1 first
        do_block("C", 2'b11, 1'b0, K0, 0, -1, '0);
        do_block("D", 2'b10, 1'b1, K0, 0, 3, K1);            // key load during decrypt
        do_block("E", 2'b01, 1'b0, K1, 0, -1, '0);           // runs on the new key

        // Reset in the middle of a decryption; the core still finishes afterwards
        bus.req_valid = 2'b10;
        wait_for("R grant", 0, 20);
        check("R req_ready", 256'(bus.req_ready), 256'(2'b10));
        @(negedge clk);
        check("R core_start", 256'(bus.core_start), 256'd1);
        bus.req_valid = 2'b00;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("R rst ctrl", 256'({bus.key_ready, bus.req_ready, bus.resp_valid, bus.resp_id,
                                  bus.core_key_start, bus.core_start, bus.timeout_err}), 256'd0);
        check("R rst data", 256'({bus.resp_plain, bus.core_cipher}), 256'd0);
        check("R rst key", bus.core_key, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1 || bus.key_ready === 1'b1) seen++;
        end
        check("R no resp after reset", 256'(seen), 256'd0);

        load_key("K0b", K0);
        do_block("F", 2'b11, 1'b0, K0, 0, -1, '0);           // pointer back at 0
        do_block("G", 2'b11, 1'b1, K0, 0, -1, '0);
        do_block("H", 2'b11, 1'b0, K0, 0, -1, '0);
        do_block("I", 2'b11, 1'b1, K0, 0, -1, '0);

        // Core that never finishes
        hang = 1'b1;
        bus.req_valid = 2'b01;
        wait_for("W grant", 0, 20);
        @(negedge clk);
        check("W core_start", 256'(bus.core_start), 256'd1);
        bus.req_valid = 2'b00;
`ifdef AES_SCHED_WATCHDOG_EN
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("W timeout cycle", 256'(n), 256'd64);
        check("W flags", 256'({bus.key_ready, bus.resp_valid, bus.timeout_err}), 256'(3'b001));
        bus.req_valid = 2'b01;
        repeat (3) @(negedge clk);
        check("W no grant in idle", 256'(bus.req_ready), 256'd0);
        bus.req_valid = 2'b00;
        bus.key_in    = K1;
        bus.key_load  = 1'b1;
        @(negedge clk);
        bus.key_load  = 1'b0;
        check("W idle accepts key", 256'({bus.core_key_start, bus.timeout_err}), 256'(2'b11));
`else
        n = 0;
        repeat (80) @(negedge clk);
        check("W no timeout", 256'({bus.timeout_err, bus.resp_valid}), 256'(n));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_scheduler.md
AES_DECRYPT_SCHEDULER -- requirements
Module: aes_decrypt_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles for one key expansion or one block decryption.
REQ-002 CLK  in  1  single clock; all state changes on the rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 key_load  in  1  one-cycle pulse; captures key_in.
REQ-005 key_in  in  256  AES-256 key.
REQ-006 key_ready  out  1  high while the expanded key is valid and no expansion is in progress.
REQ-007 req_valid  in  2  per-requester decryption request, bit i = requester i.
REQ-008 req_ready  out  2  one-cycle grant; transfer occurs when req_valid[i] & req_ready[i].
REQ-009 req_cipher0 / req_cipher1  in  128  ciphertext of requester 0 / 1.
REQ-010 resp_valid  out  1  plaintext available.
REQ-011 resp_ready  in  1  consumer accepts the response.
REQ-012 resp_id  out  1  requester that owns resp_plain.
REQ-013 resp_plain  out  128  decrypted block.
REQ-014 core_key_start, core_start  out  1  one-cycle pulses to the decryption core.
REQ-015 core_key  out  256, core_cipher  out  128  core operands, held stable for the whole operation.
REQ-016 core_plain  in  128, core_finished  in  1, core_key_finished  in  1  core results and completion pulses.
REQ-017 timeout_err  out  1  sticky watchdog flag.

Function
REQ-018 FSM states: IDLE, KEY_EXP, READY, DECRYPT, RESP.
REQ-019 IDLE: on key_load, latch key_in into core_key, pulse core_key_start for one cycle, go to KEY_EXP.
REQ-020 KEY_EXP: on core_key_finished go to READY; key_ready rises in the same cycle as the state change.
REQ-021 READY: grant one requester per decision, round-robin; the pointer toggles only after a grant; requester 0 wins first after reset.
REQ-022 On grant: latch the cipher and requester id, drive core_start high for exactly one cycle, go to DECRYPT.
REQ-023 DECRYPT: on core_finished, register core_plain into resp_plain, set resp_valid, go to RESP.
REQ-024 RESP: hold resp_valid, resp_id and resp_plain stable until resp_ready; on acceptance go to READY (or to KEY_EXP if a key load is pending); back-to-back operation costs one idle cycle.
REQ-025 Latency: grant to core_start 1 cycle; core_finished to resp_valid 1 cycle.
REQ-026 key_load in READY restarts expansion immediately; in DECRYPT or RESP it is recorded as pending and served once RESP completes; a second pending key_load overwrites the first.
REQ-027 key_ready deasserts in the cycle after key_load is accepted; no grant is issued while key_ready is low.
REQ-028 Both req_valid bits high with the pointer at 1: grant 1, then 0 on the next decision.
REQ-029 core_finished or core_key_finished in a state that does not expect it is ignored.

Reset
REQ-030 RST_N low: state IDLE; key_ready, req_ready, resp_valid, resp_id, core_key_start, core_start and timeout_err all 0; resp_plain, core_key and core_cipher all zero; round-robin pointer 0; no pending key.
REQ-031 Reset mid-operation abandons the operation; no response is produced for it.

Configuration
REQ-032 Macro AES_SCHED_WATCHDOG_EN defined: a counter runs in KEY_EXP and DECRYPT.
- Reaching TIMEOUT_CYCLES sets timeout_err and returns the FSM to IDLE; key_ready is cleared.
- timeout_err clears only on reset.
REQ-033 Macro AES_SCHED_WATCHDOG_EN undefined: no counter is built and timeout_err is tied 0.

Structure
REQ-034 Shared package aes_pkg holds the FSM state enum, the key and block width constants (256/128), and the TIMEOUT_CYCLES default.
REQ-035 Sub-module rr_arbiter2 holds the two-requester round-robin grant logic and its pointer.

Verification
REQ-036 Bench drives the DUT against a behavioural core model with 12-cycle expansion and 14-cycle decryption latency.
REQ-037 Key 000102...1e1f loaded, req0 cipher 8ea2b7ca516745bfeafc49904b496089 -> resp_plain 00112233445566778899aabbccddeeff, resp_id 0.
REQ-038 Both requesters valid for 4 blocks -> grant order 0,1,0,1; each resp_id matches its requester.
REQ-039 resp_ready held low 10 cycles -> resp_plain stable, no new core_start.
REQ-040 key_load during DECRYPT -> current block completes with the old key, then core_key_start, then key_ready high.
REQ-041 Model never raises core_finished, macro defined -> timeout_err at cycle 64 and FSM in IDLE; macro undefined -> timeout_err stays 0.
REQ-042 RST_N pulsed low mid-DECRYPT -> all outputs at reset values, no resp_valid afterwards.
